// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM state encoding and
// default geometry/starvation constants.
package sram_port_arbiter_pkg;

    localparam int DEF_ADDR_W     = 11;
    localparam int DEF_DATA_W     = 186;
    localparam int DEF_MASK_W     = 6;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sram_starve_ctr.sv
// Saturating count of consecutive arbitrations a pending write has lost.
module sram_starve_ctr #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: one read port, one masked write port, reads win
// ties unless the write has lost STARVE_MAX arbitrations in a row.
// Optional power-on clear sweep enabled by `define SRAM_INIT_CLEAR_EN.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MASK_W     = DEF_MASK_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    output logic [DATA_W-1:0] r_resp_data,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [MASK_W-1:0] w_req_mask,
    input  logic [DATA_W-1:0] w_req_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    logic run;
    logic starved;
    logic r_fire;
    logic w_fire;
    logic r_resp_valid_q;

`ifdef SRAM_INIT_CLEAR_EN
    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              sweeping;

    // State and sweep address registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Sweep is held off while reset is asserted so the SRAM stays idle.
    assign sweeping  = (state_q == INIT) && !reset;
    assign run       = (state_q == RUN);
    assign init_done = (state_q == RUN);
`else
    // No clear sweep: usable straight out of reset.
    assign run       = !reset;
    assign init_done = 1'b1;
`endif

    assign r_req_ready = run && !(w_req_valid && starved);
    assign w_req_ready = run && (!r_req_valid || starved);
    assign r_fire      = r_req_valid && r_req_ready;
    assign w_fire      = w_req_valid && w_req_ready;

    // SRAM command mux plus next-state of the clear sweep.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
`ifdef SRAM_INIT_CLEAR_EN
        state_d    = state_q;
        sweep_d    = sweep_q;
        if (sweeping) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = sweep_q;
            sram_wmask = '1;
            sweep_d    = sweep_q + ADDR_W'(1);
            if (sweep_q == '1) begin
                state_d = RUN;
            end
        end
`endif
        if (w_fire) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_req_addr;
            sram_wmask = w_req_mask;
            sram_wdata = w_req_data;
        end else if (r_fire) begin
            sram_en    = 1'b1;
            sram_addr  = r_req_addr;
        end
    end

    // Read response valid tracks the 1-cycle SRAM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resp_valid_q <= 1'b0;
        end else begin
            r_resp_valid_q <= r_fire;
        end
    end

    assign r_resp_valid = r_resp_valid_q;
    assign r_resp_data  = sram_rdata;

    sram_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clock_i (clock),
        .reset_i (reset),
        .inc_i   (w_req_valid && r_fire),
        .clr_i   (w_fire),
        .sat_o   (starved)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural lane-masked
// single-port SRAM (1-cycle read latency).
module tb_sram_port_arbiter;

    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 186;
    localparam int MASK_W     = 6;
    localparam int STARVE_MAX = 4;
    localparam int LANE_W     = DATA_W / MASK_W;
    localparam int DEPTH      = 1 << ADDR_W;
`ifdef SRAM_INIT_CLEAR_EN
    localparam logic EXP_DONE_RST = 1'b0;
`else
    localparam logic EXP_DONE_RST = 1'b1;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              r_req_valid = 1'b0;
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_req_addr = '0;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              w_req_valid = 1'b0;
    logic              w_req_ready;
    logic [ADDR_W-1:0] w_req_addr = '0;
    logic [MASK_W-1:0] w_req_mask = '0;
    logic [DATA_W-1:0] w_req_data = '0;
    logic              init_done;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic              fill_req = 1'b0;
    logic [DATA_W-1:0] fill_val = '0;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    sram_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MASK_W     (MASK_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .r_req_valid  (r_req_valid),
        .r_req_ready  (r_req_ready),
        .r_req_addr   (r_req_addr),
        .r_resp_valid (r_resp_valid),
        .r_resp_data  (r_resp_data),
        .w_req_valid  (w_req_valid),
        .w_req_ready  (w_req_ready),
        .w_req_addr   (w_req_addr),
        .w_req_mask   (w_req_mask),
        .w_req_data   (w_req_data),
        .init_done    (init_done),
        .sram_en      (sram_en),
        .sram_wmode   (sram_wmode),
        .sram_addr    (sram_addr),
        .sram_wmask   (sram_wmask),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    // Behavioural SRAM: lane-masked writes, registered read data.
    always @(posedge clock) begin
        if (fill_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= fill_val;
        end else if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < MASK_W; l++)
                    if (sram_wmask[l])
                        mem[sram_addr][l*LANE_W +: LANE_W] <= sram_wdata[l*LANE_W +: LANE_W];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        r_req_valid = 1'b0;
        w_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        settle();
        n_cmp++; if (r_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_r_ready: got %0h want 0", r_req_ready); end
        n_cmp++; if (w_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_w_ready: got %0h want 0", w_req_ready); end
        n_cmp++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL rst_sram_en: got %0h want 0", sram_en); end
        n_cmp++; if (r_resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %0h want 0", r_resp_valid); end
        n_cmp++; if (init_done !== EXP_DONE_RST) begin n_err++; $display("FAIL rst_init_done: got %0h want %0h", init_done, EXP_DONE_RST); end
        next_cycle();
        reset = 1'b0;
`ifdef SRAM_INIT_CLEAR_EN
        settle();
        c = 0;
        while (!init_done && c < 3000) begin
            next_cycle();
            settle();
            c++;
        end
        n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL init_wait: init_done=%0h after %0d cycles, want 1", init_done, c); end
`else
        c = 0;
        r_req_valid = 1'b1;
        r_req_addr  = 11'h003;
        settle();
        n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL nomacro_done: got %0h want 1", init_done); end
        n_cmp++; if (r_req_ready !== 1'b1) begin n_err++; $display("FAIL nomacro_first_rd_ready: got %0h want 1", r_req_ready); end
        n_cmp++; if ({sram_en, sram_wmode} !== 2'b10) begin n_err++; $display("FAIL nomacro_first_rd_cmd: got %b want 10", {sram_en, sram_wmode}); end
        next_cycle();
        idle_inputs();
        settle();
        n_cmp++; if (r_resp_valid !== 1'b1) begin n_err++; $display("FAIL nomacro_first_resp: got %0h want 1", r_resp_valid); end
        n_cmp++; if (r_resp_data !== '0) begin n_err++; $display("FAIL nomacro_first_data: got %0h want 0", r_resp_data); end
`endif
    endtask

`ifdef SRAM_INIT_CLEAR_EN
    task automatic test_sweep();
        int errs;
        int bad;
        errs = 0;
        bad  = -1;
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b0;
        settle();
        for (int i = 0; i < DEPTH; i++) begin
            if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== ADDR_W'(i) ||
                sram_wmask !== 6'h3F || sram_wdata !== '0 || init_done !== 1'b0 ||
                r_req_ready !== 1'b0 || w_req_ready !== 1'b0) begin
                errs++;
                if (bad < 0) bad = i;
            end
            next_cycle();
            settle();
        end
        n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL sweep_writes: %0d bad cycles (first %0d, addr %0h), want 0", errs, bad, sram_addr); end
        n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL sweep_done_2048: got %0h want 1", init_done); end
        n_cmp++; if (w_req_ready !== 1'b1) begin n_err++; $display("FAIL sweep_run_w_ready: got %0h want 1", w_req_ready); end
        next_cycle();
        r_req_valid = 1'b1;
        r_req_addr  = 11'h005;
        settle();
        n_cmp++; if ({sram_en, sram_wmode, sram_addr} !== {2'b10, 11'h005}) begin n_err++; $display("FAIL sweep_rd5_cmd: got %b/%0h want 10/5", {sram_en, sram_wmode}, sram_addr); end
        next_cycle();
        idle_inputs();
        settle();
        n_cmp++; if (r_resp_valid !== 1'b1) begin n_err++; $display("FAIL sweep_rd5_valid: got %0h want 1", r_resp_valid); end
        n_cmp++; if (r_resp_data !== '0) begin n_err++; $display("FAIL sweep_rd5_data: got %0h want 0", r_resp_data); end
        next_cycle();
        settle();
        n_cmp++; if (r_resp_valid !== 1'b0) begin n_err++; $display("FAIL sweep_rd5_single: got %0h want 0", r_resp_valid); end
    endtask
`endif

    task automatic test_write_read();
        logic [DATA_W-1:0] exp;
        exp = '0;
        exp[30:0] = 31'h1234567;
        next_cycle();
        w_req_valid = 1'b1;
        w_req_addr  = 11'h010;
        w_req_mask  = 6'h01;
        w_req_data  = '1;
        w_req_data[30:0] = 31'h1234567;
        settle();
        n_cmp++; if (w_req_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %0h want 1", w_req_ready); end
        n_cmp++; if ({sram_en, sram_wmode, sram_addr, sram_wmask} !== {2'b11, 11'h010, 6'h01}) begin n_err++; $display("FAIL wr_cmd: got %b/%0h/%0h want 11/10/1", {sram_en, sram_wmode}, sram_addr, sram_wmask); end
        next_cycle();
        w_req_valid = 1'b0;
        r_req_valid = 1'b1;
        r_req_addr  = 11'h010;
        settle();
        n_cmp++; if ({r_req_ready, sram_en, sram_wmode} !== 3'b110) begin n_err++; $display("FAIL wr_rd_cmd: got %b want 110", {r_req_ready, sram_en, sram_wmode}); end
        n_cmp++; if (r_resp_valid !== 1'b0) begin n_err++; $display("FAIL wr_no_resp: got %0h want 0", r_resp_valid); end
        next_cycle();
        idle_inputs();
        settle();
        n_cmp++; if (r_resp_valid !== 1'b1) begin n_err++; $display("FAIL wr_rd_valid: got %0h want 1", r_resp_valid); end
        n_cmp++; if (r_resp_data !== exp) begin n_err++; $display("FAIL wr_rd_data: got %0h want %0h", r_resp_data, exp); end
    endtask

    task automatic test_starvation();
        next_cycle();
        r_req_valid = 1'b1;
        r_req_addr  = 11'h030;
        w_req_valid = 1'b1;
        w_req_addr  = 11'h031;
        w_req_mask  = 6'h3F;
        w_req_data  = DATA_W'(8'h55);
        settle();
        for (int k = 1; k <= 4; k++) begin
            n_cmp++; if ({r_req_ready, w_req_ready, sram_en, sram_wmode} !== 4'b1010) begin n_err++; $display("FAIL starve_rd%0d: rr/wr/en/wm got %b want 1010", k, {r_req_ready, w_req_ready, sram_en, sram_wmode}); end
            next_cycle();
            settle();
        end
        n_cmp++; if ({r_req_ready, w_req_ready, sram_wmode, sram_addr} !== {3'b011, 11'h031}) begin n_err++; $display("FAIL starve_wr5: got %b/%0h want 011/31", {r_req_ready, w_req_ready, sram_wmode}, sram_addr); end
        n_cmp++; if (r_resp_valid !== 1'b1) begin n_err++; $display("FAIL starve_resp4: got %0h want 1", r_resp_valid); end
        next_cycle();
        settle();
        n_cmp++; if ({r_req_ready, w_req_ready, sram_wmode} !== 3'b100) begin n_err++; $display("FAIL starve_rd6: got %b want 100", {r_req_ready, w_req_ready, sram_wmode}); end
        n_cmp++; if (r_resp_valid !== 1'b0) begin n_err++; $display("FAIL starve_resp_after_wr: got %0h want 0", r_resp_valid); end
        // count is now 1; a read without a pending write must not bump it
        next_cycle();
        w_req_valid = 1'b0;
        settle();
        next_cycle();
        w_req_valid = 1'b1;
        settle();
        for (int k = 2; k <= 4; k++) begin
            n_cmp++; if ({r_req_ready, w_req_ready} !== 2'b10) begin n_err++; $display("FAIL hold_rd_cnt%0d: got %b want 10", k - 1, {r_req_ready, w_req_ready}); end
            next_cycle();
            settle();
        end
        n_cmp++; if ({r_req_ready, w_req_ready, sram_wmode} !== 3'b011) begin n_err++; $display("FAIL hold_wr: got %b want 011", {r_req_ready, w_req_ready, sram_wmode}); end
        next_cycle();
        idle_inputs();
        settle();
        n_cmp++; if ({sram_en, r_resp_valid, w_req_ready} !== 3'b001) begin n_err++; $display("FAIL idle_after_starve: en/rv/wr got %b want 001", {sram_en, r_resp_valid, w_req_ready}); end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        w_req_valid = 1'b1;
        w_req_addr  = 11'h020;
        w_req_mask  = 6'h3F;
        w_req_data  = DATA_W'(8'hAA);
        settle();
        next_cycle();
        w_req_valid = 1'b0;
        r_req_valid = 1'b1;
        r_req_addr  = 11'h020;
        settle();
        next_cycle();
        r_req_valid = 1'b0;
        w_req_valid = 1'b1;
        w_req_data  = DATA_W'(8'hBB);
        settle();
        n_cmp++; if (w_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_wr_ready: got %0h want 1", w_req_ready); end
        n_cmp++; if (r_resp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_resp_valid: got %0h want 1", r_resp_valid); end
        n_cmp++; if (r_resp_data !== DATA_W'(8'hAA)) begin n_err++; $display("FAIL b2b_old_data: got %0h want aa", r_resp_data); end
        next_cycle();
        w_req_valid = 1'b0;
        r_req_valid = 1'b1;
        settle();
        next_cycle();
        idle_inputs();
        settle();
        n_cmp++; if (r_resp_data !== DATA_W'(8'hBB)) begin n_err++; $display("FAIL b2b_new_data: got %0h want bb", r_resp_data); end
    endtask

    task automatic test_reset_midop();
        int c;
        next_cycle();
        r_req_valid = 1'b1;
        r_req_addr  = 11'h020;
        settle();
        n_cmp++; if (r_req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_rd_ready: got %0h want 1", r_req_ready); end
        next_cycle();
        reset = 1'b1;
        r_req_valid = 1'b0;
        settle();
        n_cmp++; if (r_resp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_resp: got %0h want 0", r_resp_valid); end
        n_cmp++; if ({sram_en, r_req_ready, w_req_ready} !== 3'b000) begin n_err++; $display("FAIL midrst_outs: en/rr/wr got %b want 000", {sram_en, r_req_ready, w_req_ready}); end
        next_cycle();
        settle();
        n_cmp++; if (r_resp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_resp2: got %0h want 0", r_resp_valid); end
        next_cycle();
        reset = 1'b0;
        settle();
        n_cmp++; if (r_resp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_resp3: got %0h want 0", r_resp_valid); end
`ifdef SRAM_INIT_CLEAR_EN
        n_cmp++; if ({sram_en, sram_wmode, sram_addr} !== {2'b11, 11'h000}) begin n_err++; $display("FAIL midrst_sweep0: got %b/%0h want 11/0", {sram_en, sram_wmode}, sram_addr); end
        next_cycle();
        settle();
        n_cmp++; if (sram_addr !== 11'h001) begin n_err++; $display("FAIL midrst_sweep1: got %0h want 1", sram_addr); end
        c = 0;
        while (!init_done && c < 3000) begin
            next_cycle();
            settle();
            c++;
        end
        n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL midrst_init_wait: init_done=%0h after %0d cycles, want 1", init_done, c); end
`else
        c = 0;
        n_cmp++; if ({init_done, w_req_ready} !== 2'b11) begin n_err++; $display("FAIL midrst_run: done/wr got %b want 11", {init_done, w_req_ready}); end
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef SRAM_INIT_CLEAR_EN
        fill_val = '1;
`else
        fill_val = '0;
`endif
        fill_req = 1'b1;
        next_cycle();
        fill_req = 1'b0;
        test_reset();
`ifdef SRAM_INIT_CLEAR_EN
        test_sweep();
`endif
        test_write_read();
        test_starvation();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, SRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 186, SRAM word width.
REQ-003 SHALL have parameter MASK_W, default 6, write-mask lanes; lane width is DATA_W/MASK_W = 31.
REQ-004 SHALL have parameter STARVE_MAX, default 4, consecutive lost arbitrations a pending write tolerates.
REQ-005 SHALL have ports: clock in 1, sole clock; reset in 1, asynchronous active-high reset.
REQ-006 SHALL have read request ports: r_req_valid in 1; r_req_ready out 1; r_req_addr in ADDR_W.
REQ-007 SHALL have read response ports: r_resp_valid out 1; r_resp_data out DATA_W.
REQ-008 SHALL have write request ports: w_req_valid in 1; w_req_ready out 1; w_req_addr in ADDR_W; w_req_mask in MASK_W; w_req_data in DATA_W.
REQ-009 SHALL have init_done out 1, high once the SRAM is usable.
REQ-010 SHALL have SRAM-side ports: sram_en out 1; sram_wmode out 1; sram_addr out ADDR_W; sram_wmask out MASK_W; sram_wdata out DATA_W; sram_rdata in DATA_W. These connect to a single-port, 1-cycle-read-latency, lane-masked SRAM.

Function
REQ-011 SHALL keep a two-state FSM: INIT (clear sweep) -> RUN; RUN is terminal until reset.
REQ-012 In INIT, SHALL hold r_req_ready=0 and w_req_ready=0, and issue one write per cycle with sram_wmode=1, sram_wmask all ones, sram_wdata=0, at addresses 0..2^ADDR_W-1 ascending.
REQ-013 SHALL move INIT->RUN in the cycle after the write to address 2^ADDR_W-1, with a 2^ADDR_W-cycle sweep; init_done=1 exactly when the state is RUN.
REQ-014 In RUN, a read fires on r_req_valid&&r_req_ready; a write fires on w_req_valid&&w_req_ready; at most one fires per cycle.
REQ-015 SHALL set r_req_ready = RUN && !(w_req_valid && starve_cnt==STARVE_MAX).
REQ-016 SHALL set w_req_ready = RUN && (!r_req_valid || starve_cnt==STARVE_MAX), so reads win ties unless the write is starved.
REQ-017 SHALL drive the SRAM combinationally on a fire: sram_en=1, sram_wmode=1 for writes and 0 for reads, address/mask/data from the winner; sram_en=0 otherwise.
REQ-018 SHALL assert r_resp_valid exactly one cycle after a read fire; r_resp_data SHALL equal sram_rdata while r_resp_valid is high. There is no response backpressure.
REQ-019 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment, saturating at STARVE_MAX, on each cycle with w_req_valid=1 and a read fire. It SHALL clear on a write fire and hold otherwise.
REQ-020 Same-address read then write on consecutive cycles SHALL return the pre-write data; write then read SHALL return the new data.
REQ-021 r_req_addr/w_req_* SHALL be ignored when not firing; sram_addr/wmask/wdata values when sram_en=0 are don't-care.

Reset
REQ-022 Asserting reset at any time SHALL force, immediately: state=INIT (or RUN, per REQ-025), sweep address=0, starve_cnt=0, r_resp_valid=0.
REQ-023 A read in flight when reset asserts SHALL produce no response.
REQ-024 Reset-time output values SHALL be: r_req_ready=0, w_req_ready=0, sram_en=0, r_resp_valid=0, init_done=0 (REQ-025 applies).

Configuration
REQ-025 Macro SRAM_INIT_CLEAR_EN SHALL control the clear sweep:
  - Defined: REQ-012/013 behaviour applies.
  - Undefined: the INIT state and sweep counter are removed; reset goes straight to RUN and init_done is constant 1.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (INIT, RUN) and the default ADDR_W/DATA_W/MASK_W/STARVE_MAX constants.
REQ-027 The starvation counter with saturation SHALL be the one sub-module, sram_starve_ctr; everything else is flat.

Verification
REQ-028 Bench SHALL cover the sweep (macro on): after reset, 2048 writes with addr 0..2047, wdata=0, wmask=6'h3F; init_done rises at cycle 2048; a read of addr 5 returns 0.
REQ-029 Bench SHALL cover write then read: write addr 0x10 mask 6'h01 data lane0=31'h1234567; read 0x10 next cycle -> r_resp_valid one cycle later, lane0=31'h1234567, other lanes 0.
REQ-030 Bench SHALL cover starvation: r_req_valid and w_req_valid held high; reads fire 4 cycles, write fires cycle 5, counter clears, reads resume cycle 6.
REQ-031 Bench SHALL cover read then write on the same addr 0x20 (old 0xAA, new 0xBB), back to back -> response returns 0xAA.
REQ-032 Bench SHALL cover reset mid-operation: reset asserted the cycle after a read fire -> r_resp_valid stays 0; sweep restarts at addr 0.
REQ-033 Bench SHALL cover the macro-undefined build: init_done=1 straight out of reset, and a read fires in the first cycle after reset deasserts.
